alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning ALU settle cycles before sampling; legal range 1..15.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_op  in  6  ALU function select (i,j,k,l,m,n order, MSB=i).
REQ-007 SHALL have port req_a  in  4  operand A.
REQ-008 SHALL have port req_b  in  4  operand B.
REQ-009 SHALL have port alu_x  out  4  operand A to the external combinational ALU.
REQ-010 SHALL have port alu_y  out  4  operand B to the ALU.
REQ-011 SHALL have port alu_f  out  6  function select to the ALU.
REQ-012 SHALL have port alu_res  in  8  ALU result (o..v, MSB=o).
REQ-013 SHALL have port rsp_valid  out  1  response present.
REQ-014 SHALL have port rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-015 SHALL have port rsp_data  out  8  captured ALU result.
REQ-016 SHALL have port rsp_tag  out  4  sequence tag of the response.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLING; IDLE -> SETTLING on request handshake; SETTLING -> IDLE on the edge where settle count reaches SETTLE.
REQ-018 SHALL drive req_ready = (state==IDLE) and (result FIFO occupancy < 2), combinationally from registers only.
REQ-019 SHALL register req_a/req_b/req_op onto alu_x/alu_y/alu_f at the accept edge E0 and hold them unchanged until the next accept.
REQ-020 SHALL sample alu_res into the result FIFO at edge E0+SETTLE, together with the tag assigned at E0.
REQ-021 SHALL make rsp_valid high in the cycle after E0+SETTLE when FIFO was empty (minimum latency SETTLE+1 cycles accept-to-rsp_valid visible).
REQ-022 SHALL assign tags from a 4-bit counter incremented per accept, wrapping 15 -> 0.
REQ-023 SHALL hold at most one request in flight; no accept in SETTLING.
REQ-024 SHALL implement a 2-entry FIFO; rsp_data/rsp_tag come from head entry and are stable while rsp_valid and not rsp_ready.
REQ-025 SHALL, on simultaneous push (sample) and pop, keep occupancy unchanged and preserve order.
REQ-026 SHALL never push into a full FIFO; REQ-018 guarantees room, and FIFO full blocks only new accepts, not an in-flight sample.
REQ-027 SHALL permit accept in the same cycle a pop makes room only if occupancy<2 before the edge (no combinational ready from rsp_ready).

Reset
REQ-028 SHALL, on rst assertion, asynchronously force: state IDLE, settle count 0, tag 0, FIFO empty, rsp_valid 0, rsp_data 0, rsp_tag 0, alu_x/alu_y/alu_f 0.
REQ-029 SHALL discard any in-flight request when rst asserts mid-SETTLING; no response issued for it.
REQ-030 SHALL hold req_ready low while rst is high and accept no request at the edge rst deasserts.

Structure
REQ-031 SHALL place FSM state enum, FIFO depth (2), and field widths (4/6/8/4) in shared package alu_pkg.
REQ-032 SHALL implement the result FIFO as sub-module alu_rsp_fifo (depth 2, width 12); FSM and tag counter stay in alu_driver.

Verification
REQ-033 Bench ALU stub SHALL return alu_res = {alu_x, alu_y} combinationally; scenarios below use SETTLE=1 unless stated.
REQ-034 Single op: req a=0x3, b=0xC, op=0x15, rsp_ready=1 -> alu_f=0x15 after E0, rsp_valid one cycle after E0+1, rsp_data=0x3C, rsp_tag=0.
REQ-035 Backpressure: rsp_ready=0, send 3 requests -> first two complete (tags 0,1), req_ready low, third stalls; raise rsp_ready -> data 0x..,tags 0,1,2 in order, none lost.
REQ-036 Tag wrap: 17 back-to-back requests, rsp_ready=1 -> tags 0..15 then 0; throughput one op per 2 cycles.
REQ-037 SETTLE=4: accept at E0 -> sample at E0+4, rsp_valid visible at E0+5; req_ready low cycles E0+1..E0+4.
REQ-038 Reset mid-op: assert rst at E0+1 with SETTLE=4 -> all outputs 0 immediately, no response for that request, next request gets tag 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU driver and its result FIFO.
package alu_pkg;

  localparam int unsigned A_W        = 4;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned RES_W      = 8;
  localparam int unsigned TAG_W      = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Two-entry result FIFO; head entry is presented combinationally from storage.
module alu_rsp_fifo
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_t       push_data,
  input  logic       pop,
  output rsp_t       head,
  output logic [1:0] count
);

  rsp_t mem [FIFO_DEPTH];
  logic rd_ptr;
  logic wr_ptr;
  logic do_push;
  logic do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (count != 2'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_driver.sv
// Drives an external combinational ALU: registers one request, waits SETTLE
// cycles, then captures the result with its sequence tag into a response FIFO.
module alu_driver
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [A_W-1:0]   req_a,
  input  logic [A_W-1:0]   req_b,
  output logic [A_W-1:0]   alu_x,
  output logic [A_W-1:0]   alu_y,
  output logic [OP_W-1:0]  alu_f,
  input  logic [RES_W-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag
);

  state_t           state;
  state_t           state_nxt;
  logic             ready_en;
  logic [CNT_W-1:0] settle_cnt;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] inflight_tag;
  logic [1:0]       fifo_count;
  rsp_t             fifo_head;
  rsp_t             push_data;
  logic             accept;
  logic             sample;
  logic             pop;

  // ready_en stays low through reset and the first edge after it, so a
  // request held across reset release is not taken on that edge.
  assign req_ready = ready_en && (state == IDLE) && (fifo_count < 2'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign sample    = (state == SETTLING) && (settle_cnt == CNT_W'(SETTLE));
  assign rsp_valid = (fifo_count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_head.data;
  assign rsp_tag   = fifo_head.tag;
  assign push_data = '{data: alu_res, tag: inflight_tag};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SETTLING;
      SETTLING: if (sample) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      settle_cnt   <= '0;
      tag_cnt      <= '0;
      inflight_tag <= '0;
      alu_x        <= '0;
      alu_y        <= '0;
      alu_f        <= '0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        alu_x        <= req_a;
        alu_y        <= req_b;
        alu_f        <= req_op;
        inflight_tag <= tag_cnt;
        tag_cnt      <= tag_cnt + 1'b1;
        settle_cnt   <= CNT_W'(1);
      end else if ((state == SETTLING) && !sample) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  alu_rsp_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sample),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver with SETTLE=1 and SETTLE=4 instances.
module tb_alu_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  logic       rst1, req_valid1, req_ready1, rsp_valid1, rsp_ready1;
  logic [5:0] req_op1, alu_f1;
  logic [3:0] req_a1, req_b1, alu_x1, alu_y1, rsp_tag1;
  logic [7:0] alu_res1, rsp_data1;

  logic       rst4, req_valid4, req_ready4, rsp_valid4, rsp_ready4;
  logic [5:0] req_op4, alu_f4;
  logic [3:0] req_a4, req_b4, alu_x4, alu_y4, rsp_tag4;
  logic [7:0] alu_res4, rsp_data4;

  assign alu_res1 = {alu_x1, alu_y1};
  assign alu_res4 = {alu_x4, alu_y4};

  alu_driver #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op1), .req_a(req_a1), .req_b(req_b1),
    .alu_x(alu_x1), .alu_y(alu_y1), .alu_f(alu_f1), .alu_res(alu_res1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_data(rsp_data1), .rsp_tag(rsp_tag1)
  );

  alu_driver #(.SETTLE(4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op4), .req_a(req_a4), .req_b(req_b4),
    .alu_x(alu_x4), .alu_y(alu_y4), .alu_f(alu_f4), .alu_res(alu_res4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_data(rsp_data4), .rsp_tag(rsp_tag4)
  );

  int vecs = 0;
  int misses = 0;
  logic [11:0] q1[$];
  logic [11:0] q4[$];
  logic [3:0]  tag1 = 4'd0;
  logic [3:0]  tag4 = 4'd0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst1 && rsp_valid1 && rsp_ready1) begin
      if (q1.size() == 0) begin
        vecs++; misses++;
        $display("FAIL d1_unexpected_rsp: got data 0x%0h tag %0d expected no response", rsp_data1, rsp_tag1);
      end else begin
        check("d1_rsp", 32'({rsp_data1, rsp_tag1}), 32'(q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst4 && rsp_valid4 && rsp_ready4) begin
      if (q4.size() == 0) begin
        vecs++; misses++;
        $display("FAIL d4_unexpected_rsp: got data 0x%0h tag %0d expected no response", rsp_data4, rsp_tag4);
      end else begin
        check("d4_rsp", 32'({rsp_data4, rsp_tag4}), 32'(q4.pop_front()));
      end
    end
  end

  // Presents a request, waits (bounded) for acceptance, returns 1 ns after the accept edge.
  task automatic send(input bit d4, input logic [3:0] a, input logic [3:0] b,
                      input logic [5:0] op, input bit expect_rsp);
    bit ok = 1'b0;
    if (d4) begin req_a4 = a; req_b4 = b; req_op4 = op; req_valid4 = 1'b1; end
    else    begin req_a1 = a; req_b1 = b; req_op1 = op; req_valid1 = 1'b1; end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((d4 && req_ready4) || (!d4 && req_ready1)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vecs++; misses++;
      $display("FAIL send_timeout: got no req_ready in 100 cycles expected accept (dut%0d)", d4 ? 4 : 1);
    end else if (expect_rsp) begin
      if (d4) begin q4.push_back({a, b, tag4}); tag4++; end
      else    begin q1.push_back({a, b, tag1}); tag1++; end
    end
    @(posedge clk);
    #1;
    acc_cyc = cycle;
    if (d4) req_valid4 = 1'b0;
    else    req_valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    int first_cyc;
    rst1 = 1'b1; rst4 = 1'b1;
    req_valid1 = 1'b0; req_valid4 = 1'b0;
    rsp_ready1 = 1'b0; rsp_ready4 = 1'b0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    req_a4 = '0; req_b4 = '0; req_op4 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    req_valid1 = 1'b1;
    check("rst_req_ready", 32'(req_ready1), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_rsp_fields", 32'({rsp_data1, rsp_tag1}), 32'd0);
    check("rst_alu_outs", 32'({alu_x1, alu_y1, alu_f1}), 32'd0);
    rst1 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;
    check("rst_release_no_accept", 32'({alu_x1, alu_f1}), 32'd0);
    check("ready_after_reset", 32'(req_ready1), 32'd1);
    req_valid1 = 1'b0;

    // Single op
    rsp_ready1 = 1'b1;
    send(1'b0, 4'h3, 4'hC, 6'h15, 1'b1);
    check("s1_alu_f", 32'(alu_f1), 32'h15);
    check("s1_alu_xy", 32'({alu_x1, alu_y1}), 32'h3C);
    check("s1_ready_low", 32'(req_ready1), 32'd0);
    check("s1_rsp_not_yet", 32'(rsp_valid1), 32'd0);
    @(posedge clk); #1;
    check("s1_rsp_valid", 32'(rsp_valid1), 32'd1);
    check("s1_rsp_data_tag", 32'({rsp_data1, rsp_tag1}), 32'h3C0);
    @(posedge clk); #1;
    check("s1_rsp_drained", 32'(rsp_valid1), 32'd0);

    // Backpressure: two fill the FIFO, third stalls until a pop frees room
    rsp_ready1 = 1'b0;
    send(1'b0, 4'h1, 4'h2, 6'h01, 1'b1);
    send(1'b0, 4'h4, 4'h5, 6'h02, 1'b1);
    @(posedge clk); #1;
    check("bp_full_ready_low", 32'(req_ready1), 32'd0);
    check("bp_head", 32'({rsp_valid1, rsp_data1, rsp_tag1}), 32'h1121);
    req_a1 = 4'h7; req_b1 = 4'h8; req_op1 = 6'h03; req_valid1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_third_stalled", 32'(alu_x1), 32'h4);
    check("bp_still_not_ready", 32'(req_ready1), 32'd0);
    check("bp_head_stable", 32'({rsp_data1, rsp_tag1}), 32'h121);
    rsp_ready1 = 1'b1;
    send(1'b0, 4'h7, 4'h8, 6'h03, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained", 32'(q1.size()), 32'd0);

    // Tag wrap after a fresh reset: tags 0..15 then 0, one op per two cycles
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    tag1 = 4'd0;
    @(posedge clk); #1;
    first_cyc = 0;
    for (int i = 0; i < 17; i++) begin
      send(1'b0, i[3:0], ~i[3:0], 6'(i), 1'b1);
      if (i == 0) first_cyc = acc_cyc;
    end
    check("wrap_throughput", 32'(acc_cyc - first_cyc), 32'd32);
    check("wrap_tag_counter", 32'(tag1), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("wrap_drained", 32'(q1.size()), 32'd0);

    // SETTLE=4 latency
    send(1'b1, 4'h9, 4'h6, 6'h2A, 1'b1);
    check("s4_alu_f", 32'(alu_f4), 32'h2A);
    for (int k = 0; k < 4; k++) begin
      check("s4_ready_low", 32'(req_ready4), 32'd0);
      check("s4_rsp_not_yet", 32'(rsp_valid4), 32'd0);
      @(posedge clk); #1;
    end
    check("s4_rsp_valid", 32'(rsp_valid4), 32'd1);
    check("s4_rsp_data_tag", 32'({rsp_data4, rsp_tag4}), 32'h960);
    check("s4_ready_back", 32'(req_ready4), 32'd1);
    rsp_ready4 = 1'b1;
    @(posedge clk); #1;

    // Reset mid-op on the SETTLE=4 instance: no response, tags restart at 0
    send(1'b1, 4'hA, 4'hB, 6'h3F, 1'b0);
    @(posedge clk); #1;
    rst4 = 1'b1;
    #1;
    check("mid_rst_alu_outs", 32'({alu_x4, alu_y4, alu_f4}), 32'd0);
    check("mid_rst_rsp", 32'({rsp_valid4, rsp_data4, rsp_tag4}), 32'd0);
    check("mid_rst_ready", 32'(req_ready4), 32'd0);
    req_a4 = 4'h5; req_b4 = 4'h6; req_op4 = 6'h01; req_valid4 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst4 = 1'b0;
    tag4 = 4'd0;
    @(posedge clk); #1;
    check("mid_rst_release_no_accept", 32'({alu_x4, alu_f4}), 32'd0);
    check("mid_rst_no_rsp", 32'(rsp_valid4), 32'd0);
    send(1'b1, 4'h5, 4'h6, 6'h01, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    check("final_q1_empty", 32'(q1.size()), 32'd0);
    check("final_q4_empty", 32'(q4.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

endmodule
